// File: rtl/z80_alu_mem_seq_pkg.sv
// rtl/z80_alu_mem_seq_pkg.sv - ALU function, operand source, flag and state encodings
package z80_alu_mem_seq_pkg;

  typedef enum logic [2:0] {
    ALU_FUNC_ADD = 3'd0,
    ALU_FUNC_ADC = 3'd1,
    ALU_FUNC_SUB = 3'd2,
    ALU_FUNC_SBC = 3'd3,
    ALU_FUNC_AND = 3'd4,
    ALU_FUNC_XOR = 3'd5,
    ALU_FUNC_OR  = 3'd6,
    ALU_FUNC_CP  = 3'd7
  } alu_func_e;

  typedef enum logic [1:0] {
    ALU_SRC_HL  = 2'd0,
    ALU_SRC_IX  = 2'd1,
    ALU_SRC_IY  = 2'd2,
    ALU_SRC_IMM = 2'd3
  } alu_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_READ = 2'd2,
    ST_EXEC = 2'd3
  } seq_state_e;

  localparam int FLAG_S_BIT  = 7;
  localparam int FLAG_Z_BIT  = 6;
  localparam int FLAG_Y_BIT  = 5;
  localparam int FLAG_H_BIT  = 4;
  localparam int FLAG_X_BIT  = 3;
  localparam int FLAG_PV_BIT = 2;
  localparam int FLAG_N_BIT  = 1;
  localparam int FLAG_C_BIT  = 0;

  // Index base plus signed displacement, wrapping in the 64K space.
  function automatic logic [15:0] idx_addr(input logic [15:0] base, input logic [7:0] d);
    return base + {{8{d[7]}}, d};
  endfunction

endpackage

// File: rtl/z80_alu_mem_seq_if.sv
// rtl/z80_alu_mem_seq_if.sv - wait-state memory read port between sequencer and bus
interface z80_alu_mem_seq_if;
  logic        mem_rd_req;
  logic [15:0] mem_raddr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_rd_req, mem_raddr, input mem_rd_ack, mem_rdata);
  modport slave  (input mem_rd_req, mem_raddr, output mem_rd_ack, mem_rdata);
endinterface

// File: rtl/z80_alu8.sv
// rtl/z80_alu8.sv - combinational 8-bit ALU group: result and flags from A, operand, F
module z80_alu8
  import z80_alu_mem_seq_pkg::*;
#(
  parameter bit XY_MODE = 1'b0
) (
  input  alu_func_e   op,
  input  logic [7:0]  a,
  input  logic [7:0]  operand,
  input  logic        carry_in,
  input  logic [7:0]  f_in,
  output logic [7:0]  result,
  output logic [7:0]  flags
);

  logic       is_sub;
  logic       is_logic;
  logic [7:0] b;
  logic       cin;
  logic [8:0] sum;
  logic [7:0] logic_res;

  always_comb begin
    is_sub   = (op == ALU_FUNC_SUB) || (op == ALU_FUNC_SBC) || (op == ALU_FUNC_CP);
    is_logic = (op == ALU_FUNC_AND) || (op == ALU_FUNC_XOR) || (op == ALU_FUNC_OR);
    // Subtraction as A + ~B + ~borrow; carry and half-carry come out inverted.
    b        = is_sub ? ~operand : operand;
    cin      = is_sub ? ~carry_in : carry_in;
    sum      = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    case (op)
      ALU_FUNC_AND: logic_res = a & operand;
      ALU_FUNC_XOR: logic_res = a ^ operand;
      default:      logic_res = a | operand;
    endcase
    result = is_logic ? logic_res : sum[7:0];

    flags              = f_in;
    flags[FLAG_S_BIT]  = result[7];
    flags[FLAG_Z_BIT]  = (result == 8'h00);
    flags[FLAG_H_BIT]  = is_logic ? (op == ALU_FUNC_AND) : (a[4] ^ b[4] ^ sum[4] ^ is_sub);
    flags[FLAG_PV_BIT] = is_logic ? ~^result : (a[7] ^ b[7] ^ sum[7] ^ sum[8]);
    flags[FLAG_N_BIT]  = is_sub;
    flags[FLAG_C_BIT]  = is_logic ? 1'b0 : (sum[8] ^ is_sub);
    if (XY_MODE) begin
      flags[FLAG_Y_BIT] = (op == ALU_FUNC_CP) ? operand[5] : result[5];
      flags[FLAG_X_BIT] = (op == ALU_FUNC_CP) ? operand[3] : result[3];
    end
  end

endmodule

// File: rtl/z80_alu_mem_seq.sv
// rtl/z80_alu_mem_seq.sv - multi-cycle ALU sequencer for (HL), (IX+d), (IY+d) and n operands
module z80_alu_mem_seq
  import z80_alu_mem_seq_pkg::*;
#(
  parameter int IDX_WAIT = 5,
  parameter bit XY_MODE  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [1:0]                 src,
  input  logic [7:0]                 disp,
  input  logic [7:0]                 a_in,
  input  logic [7:0]                 f_in,
  input  logic [15:0]                hl,
  input  logic [15:0]                ix,
  input  logic [15:0]                iy,
  z80_alu_mem_seq_if.master          mem,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 a_out,
  output logic [7:0]                 f_out
);

  seq_state_e state;
  alu_src_e   src_sel;
  alu_func_e  op_q;
  logic [3:0] wait_cnt;
  logic [7:0] a_q;
  logic [7:0] f_q;
  logic [7:0] operand_q;
  logic [7:0] alu_res;
  logic [7:0] alu_flags;

  assign src_sel = alu_src_e'(src);
  assign busy    = (state != ST_IDLE);

  z80_alu8 #(.XY_MODE(XY_MODE)) u_alu (
    .op       (op_q),
    .a        (a_q),
    .operand  (operand_q),
    .carry_in (f_q[FLAG_C_BIT] & ((op_q == ALU_FUNC_ADC) || (op_q == ALU_FUNC_SBC))),
    .f_in     (f_q),
    .result   (alu_res),
    .flags    (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      op_q           <= ALU_FUNC_ADD;
      wait_cnt       <= '0;
      a_q            <= '0;
      f_q            <= '0;
      operand_q      <= '0;
      mem.mem_rd_req <= 1'b0;
      mem.mem_raddr  <= '0;
      done           <= 1'b0;
      a_out          <= 8'hFF;
      f_out          <= 8'hFF;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= alu_func_e'(op);
            a_q       <= a_in;
            f_q       <= f_in;
            operand_q <= disp;
            wait_cnt  <= '0;
            case (src_sel)
              ALU_SRC_HL: mem.mem_raddr <= hl;
              ALU_SRC_IX: mem.mem_raddr <= idx_addr(ix, disp);
              ALU_SRC_IY: mem.mem_raddr <= idx_addr(iy, disp);
              default:    mem.mem_raddr <= mem.mem_raddr;
            endcase
            if (src_sel == ALU_SRC_IMM) begin
              state <= ST_EXEC;
            end else if (src_sel != ALU_SRC_HL && IDX_WAIT > 0) begin
              state <= ST_ADDR;
            end else begin
              state          <= ST_READ;
              mem.mem_rd_req <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (wait_cnt == 4'(IDX_WAIT - 1)) begin
            state          <= ST_READ;
            mem.mem_rd_req <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_READ: begin
          if (mem.mem_rd_ack) begin
            operand_q      <= mem.mem_rdata;
            mem.mem_rd_req <= 1'b0;
            state          <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          a_out <= (op_q == ALU_FUNC_CP) ? a_q : alu_res;
          f_out <= alu_flags;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_alu_mem_seq.sv
// tb/tb_z80_alu_mem_seq.sv - randomized bench with behavioural model for z80_alu_mem_seq
module tb_z80_alu_mem_seq;
  import z80_alu_mem_seq_pkg::*;

  localparam int IDXW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start;
  logic [2:0]  op;
  logic [1:0]  src;
  logic [7:0]  disp, a_in, f_in;
  logic [15:0] hl, ix, iy;
  logic        busy0, done0, busy1, done1;
  logic [7:0]  a0, f0, a1, f1;

  z80_alu_mem_seq_if m0();
  z80_alu_mem_seq_if m1();

  z80_alu_mem_seq #(.IDX_WAIT(IDXW), .XY_MODE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src(src), .disp(disp),
    .a_in(a_in), .f_in(f_in), .hl(hl), .ix(ix), .iy(iy), .mem(m0),
    .busy(busy0), .done(done0), .a_out(a0), .f_out(f0)
  );

  z80_alu_mem_seq #(.IDX_WAIT(IDXW), .XY_MODE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src(src), .disp(disp),
    .a_in(a_in), .f_in(f_in), .hl(hl), .ix(ix), .iy(iy), .mem(m1),
    .busy(busy1), .done(done1), .a_out(a1), .f_out(f1)
  );

  typedef struct {
    int          t0;
    int          rs;
    int          ack_c;
    int          td;
    bit          imm;
    logic [15:0] addr;
    logic [7:0]  ra;
    logic [7:0]  rf0;
    logic [7:0]  rf1;
  } op_rec_t;

  op_rec_t     q[$];
  logic [7:0]  mem [0:65535];
  logic [7:0]  cur_a = 8'hFF, cur_f0 = 8'hFF, cur_f1 = 8'hFF;
  int          cyc = 0;
  int          checks = 0, errors = 0, done_seen = 0;
  int          ack_delay = 0, wait_cnt = 0, req_len = 0, first_req_cyc = -1;
  logic [15:0] first_req_addr = 16'h0;
  bit          stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic int sx(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference ALU from the Z80 flag rules, using plain integer arithmetic.
  function automatic void alu_ref(input int fn, input int a, input int b, input logic [7:0] fi,
                                  input bit xy, output logic [7:0] ra, output logic [7:0] rf);
    int c, r, sr;
    bit hf, vf, cf, nf, lg;
    logic [7:0] res, bb;
    c = (fn == 1 || fn == 3) ? int'(fi[0]) : 0;
    hf = 0; vf = 0; cf = 0; nf = 0; lg = 0; sr = 0;
    case (fn)
      0, 1: begin
        r = a + b + c; hf = ((a % 16) + (b % 16) + c) > 15;
        sr = sx(a) + sx(b) + c; cf = (r > 255);
      end
      2, 3, 7: begin
        r = a - b - c; hf = ((a % 16) - (b % 16) - c) < 0;
        sr = sx(a) - sx(b) - c; cf = (r < 0); nf = 1;
      end
      4: begin r = a & b; hf = 1; lg = 1; end
      5: begin r = a ^ b; lg = 1; end
      default: begin r = a | b; lg = 1; end
    endcase
    res = r[7:0];
    bb  = b[7:0];
    vf  = lg ? ($countones(res) % 2 == 0) : (sr > 127 || sr < -128);
    rf = fi;
    rf[7] = res[7]; rf[6] = (res == 8'h00); rf[4] = hf; rf[2] = vf; rf[1] = nf; rf[0] = cf;
    if (xy) begin
      rf[5] = (fn == 7) ? bb[5] : res[5];
      rf[3] = (fn == 7) ? bb[3] : res[3];
    end
    ra = (fn == 7) ? a[7:0] : res;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d,
                       input logic [7:0] a, input logic [7:0] f, input logic [15:0] h,
                       input logic [15:0] x, input logic [15:0] y, input int dly,
                       output op_rec_t r);
    logic [15:0] base;
    int operand;
    op = o; src = s; disp = d; a_in = a; f_in = f; hl = h; ix = x; iy = y;
    start = 1'b1; ack_delay = dly;
    base    = (s == 2'd1) ? x : y;
    r.t0    = cyc;
    r.imm   = (s == 2'd3);
    r.addr  = (s == 2'd0) ? h : 16'(int'(base) + sx(int'(d)));
    r.rs    = cyc + 1 + ((s == 2'd1 || s == 2'd2) ? IDXW : 0);
    r.ack_c = r.rs + dly;
    r.td    = r.imm ? cyc + 2 : r.ack_c + 2;
    operand = r.imm ? int'(d) : int'(mem[r.addr]);
    alu_ref(int'(o), int'(a), operand, f, 1'b0, r.ra, r.rf0);
    alu_ref(int'(o), int'(a), operand, f, 1'b1, r.ra, r.rf1);
    q.push_back(r);
    req_len = 0; first_req_cyc = -1;
  endtask

  // Leaves the bench in the done cycle; noisy keeps start high with junk inputs while busy.
  task automatic run_op(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d,
                        input logic [7:0] a, input logic [7:0] f, input logic [15:0] h,
                        input logic [15:0] x, input logic [15:0] y, input int dly,
                        input bit noisy, output op_rec_t r);
    issue(o, s, d, a, f, h, x, y, dly, r);
    while (cyc < r.td) begin
      step();
      if (cyc < r.td) begin
        if (noisy) begin
          op = 3'($urandom); src = 2'($urandom); disp = 8'($urandom);
          a_in = 8'($urandom); f_in = 8'($urandom);
          hl = 16'($urandom); ix = 16'($urandom); iy = 16'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
  endtask

  initial begin
    m0.mem_rd_ack = 1'b0; m1.mem_rd_ack = 1'b0;
    m0.mem_rdata = 8'h00; m1.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (m0.mem_rd_req === 1'b1) begin
        if (req_len == 0) begin
          first_req_cyc  = cyc;
          first_req_addr = m0.mem_raddr;
        end
        req_len++;
        m0.mem_rd_ack = (wait_cnt >= ack_delay);
        m0.mem_rdata  = mem[m0.mem_raddr];
        if (wait_cnt < ack_delay) wait_cnt++;
      end else begin
        wait_cnt = 0;
        m0.mem_rd_ack = stray;
        m0.mem_rdata  = 8'($urandom);
      end
      m1.mem_rd_ack = m0.mem_rd_ack;
      m1.mem_rdata  = m0.mem_rdata;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      automatic logic eb, er, ed;
      automatic logic [15:0] ea;
      automatic logic [7:0] xa, x0, x1;
      while (q.size() > 0 && cyc > q[0].td) begin
        cur_a = q[0].ra; cur_f0 = q[0].rf0; cur_f1 = q[0].rf1;
        void'(q.pop_front());
      end
      eb = 1'b0; er = 1'b0; ed = 1'b0; ea = 16'h0;
      xa = cur_a; x0 = cur_f0; x1 = cur_f1;
      if (q.size() > 0 && cyc >= q[0].t0 + 1) begin
        eb = (cyc < q[0].td);
        er = !q[0].imm && cyc >= q[0].rs && cyc <= q[0].ack_c;
        ea = q[0].addr;
        if (cyc == q[0].td) begin
          ed = 1'b1; xa = q[0].ra; x0 = q[0].rf0; x1 = q[0].rf1;
        end
      end
      check("busy0", busy0, eb);
      check("busy1", busy1, eb);
      check("done0", done0, ed);
      check("done1", done1, ed);
      check("req0", m0.mem_rd_req, er);
      check("req1", m1.mem_rd_req, er);
      if (er) begin
        check("raddr0", m0.mem_raddr, ea);
        check("raddr1", m1.mem_raddr, ea);
      end
      check("a_out0", a0, xa);
      check("a_out1", a1, xa);
      check("f_out0", f0, x0);
      check("f_out1", f1, x1);
      if (done0 === 1'b1) done_seen++;
      if (reset_n !== 1'b1) begin
        q.delete();
        cur_a = 8'hFF; cur_f0 = 8'hFF; cur_f1 = 8'hFF;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    op_rec_t r;
    int d0;
    logic [15:0] h;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; src = 2'd0; disp = 8'h00;
    a_in = 8'h00; f_in = 8'h00; hl = 16'h0; ix = 16'h0; iy = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) step();
    check("reset_a_out", a0, 8'hFF);
    check("reset_f_out", f0, 8'hFF);
    check("reset_busy", busy0, 1'b0);
    check("reset_raddr", m0.mem_raddr, 16'h0000);
    reset_n = 1'b1;
    step();

    mem[16'h1005] = 8'h3C;
    run_op(3'd0, 2'd1, 8'h05, 8'h44, 8'h00, 16'h0000, 16'h1000, 16'h2222, 0, 1'b0, r);
    check("model_add_a", r.ra, 8'h80);
    check("model_add_f", r.rf0, 8'h94);
    check("add_ix_req_cycle", first_req_cyc - r.t0, 6);
    check("add_ix_addr", first_req_addr, 16'h1005);
    check("add_ix_a", a0, 8'h80);
    check("add_ix_f", f0, 8'h94);
    start = 1'b0; step();

    mem[16'h0001] = 8'h01;
    run_op(3'd2, 2'd2, 8'hFE, 8'h10, 8'h00, 16'h0000, 16'h0000, 16'h0003, 3, 1'b0, r);
    check("sub_iy_addr", first_req_addr, 16'h0001);
    check("sub_iy_req_len", req_len, 4);
    check("sub_iy_a", a0, 8'h0F);
    check("sub_iy_f", f0, 8'h12);
    start = 1'b0; step();
    run_op(3'd2, 2'd1, 8'h02, 8'h10, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 1, 1'b0, r);
    check("sub_ix_wrap_addr", first_req_addr, 16'h0001);
    check("sub_ix_wrap_f", f0, 8'h12);

    run_op(3'd7, 2'd3, 8'h28, 8'h20, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, r);
    check("model_cp_f", r.rf1, 8'hBB);
    check("cp_imm_done", done1, 1'b1);
    check("cp_imm_no_req", req_len, 0);
    check("cp_imm_a", a1, 8'h20);
    check("cp_imm_f", f1, 8'hBB);
    start = 1'b0; step();

    h = 16'h4321; mem[h] = 8'h00;
    run_op(3'd3, 2'd0, 8'h77, 8'h00, 8'h01, h, 16'h0000, 16'h0000, 0, 1'b0, r);
    check("sbc_hl_a", a0, 8'hFF);
    check("sbc_hl_f", f0, 8'h93);
    run_op(3'd3, 2'd0, 8'h77, 8'h00, 8'h29, h, 16'h0000, 16'h0000, 2, 1'b0, r);
    check("sbc_hl_f_keep53", f0, 8'hBB);
    start = 1'b0; step();

    issue(3'd0, 2'd0, 8'h00, 8'h12, 8'h00, 16'h0100, 16'h0000, 16'h0000, 10, r);
    step(); start = 1'b0;
    while (cyc < r.rs + 1) step();
    d0 = done_seen;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check("midreset_req", m0.mem_rd_req, 1'b0);
    check("midreset_busy", busy0, 1'b0);
    check("midreset_a", a0, 8'hFF);
    check("midreset_f", f0, 8'hFF);
    repeat (16) step();
    check("midreset_no_done", done_seen - d0, 0);
    run_op(3'd5, 2'd0, 8'h00, 8'h5A, 8'h00, 16'h0200, 16'h0000, 16'h0000, 1, 1'b0, r);
    start = 1'b0; step();

    d0 = done_seen; stray = 1'b1;
    run_op(3'd1, 2'd1, 8'h80, 8'h33, 8'h01, 16'h0000, 16'h8000, 16'h0000, 2, 1'b1, r);
    start = 1'b0; stray = 1'b0; step();
    check("held_start_one_done", done_seen - d0, 1);
    step();

    for (int n = 0; n < 300; n++) begin
      stray = ($urandom_range(0, 4) == 0);
      run_op(3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0), r);
      if ($urandom_range(0, 1) == 0) begin
        start = 1'b0;
        step();
      end
    end
    start = 1'b0; stray = 1'b0;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_alu_mem_seq.md
# z80_alu_mem_seq

Multi-cycle sequencer that executes the Z80 8-bit ALU group (ADD/ADC/SUB/SBC/AND/XOR/OR/CP A, src) for four operand sources: (HL), (IX+d), (IY+d) and immediate n. It computes the effective address, reads memory through a wait-state req/ack port, applies the ALU function and returns registered A and F with a one-cycle done strobe. It sits between the core's decode/sequencer and the memory bus interface. It generalises the single-mode indexed ALU behaviour to all sources, with configurable index-address latency, memory wait states and undocumented-flag mode.

## Interface
Parameters:
- IDX_WAIT, 5, internal cycles spent in ADDR for IX/IY modes (0..15); HL and immediate modes never use ADDR
- XY_MODE, 0, 0: F bits 5/3 preserved from f_in; 1: bits 5/3 copied from result (from operand for CP)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  ALU function, `ALU_FUNC_*` encoding
- src  in  2  0 (HL), 1 (IX+d), 2 (IY+d), 3 immediate
- disp  in  8  signed displacement d, or immediate n when src=3
- a_in, f_in  in  8 each  A and F at start
- hl, ix, iy  in  16 each  base registers at start
- mem_rd_req  out  1  read request
- mem_raddr  out  16  read address, stable while req=1
- mem_rd_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  8  read data
- busy  out  1  state != IDLE
- done  out  1  one-cycle strobe; a_out/f_out updated
- a_out, f_out  out  8 each  results

## Operation
- States: IDLE, ADDR, READ, EXEC.
- IDLE: start=1 captures op, src, disp, a_in, f_in; address = hl (src 0) or ix/iy + sign_extend(disp), mod 2^16. Next: EXEC if src=3; ADDR if src 1/2 and IDX_WAIT>0; else READ.
- ADDR: count IDX_WAIT cycles, then READ. mem_rd_req=0.
- READ: mem_rd_req=1, mem_raddr=captured address. On mem_rd_ack=1, latch mem_rdata as operand, go to EXEC. ack on the first READ cycle is legal.
- EXEC: compute; at edge register a_out, f_out, done=1; go to IDLE.
- Arithmetic: carry_in = f_in.C for ADC/SBC only. SUB/SBC/CP use A + ~operand + (1 ^ carry_in); C is the inverted carry-out.
- Flags: S=result[7]; Z=(result==0); H=half-carry/borrow from bit 3, 1 for AND, 0 for XOR/OR; P/V=overflow for arith, even parity for logical; N=1 for SUB/SBC/CP; C=0 for logical.
- a_out = a_in for CP, else result.
- start while busy: ignored. mem_rd_ack outside READ: ignored.

## Timing
- Reset values: busy=0, done=0, mem_rd_req=0, mem_raddr=0, a_out=8'hFF, f_out=8'hFF, state IDLE.
- Reset during any state: next cycle IDLE, req=0, done never fires for the aborted op; a_out/f_out return to FF.
- Immediate: start cycle 0 → EXEC cycle 1 → done cycle 2.
- (HL): start cycle 0 → READ from cycle 1; ack in cycle N → EXEC N+1 → done N+2.
- Indexed: READ starts at cycle IDX_WAIT+1.
- done cycle is IDLE; a new start is accepted in that cycle.
- a_out/f_out hold between operations.

## Structure
- z80.vh gains `ALU_SRC_HL/IX/IY/IMM`; existing `ALU_FUNC_*` and `FLAG_*_BIT` are reused.
- Sub-module z80_alu8: combinational (op, a, operand, carry_in, f_in, XY_MODE) → result, flags. It is shared with the register-source ALU path.
- z80_alu_mem_seq holds only the FSM, wait counter, capture registers and address adder.

## Test plan
- ADD, src=IX, IX=16'h1000, d=8'h05, mem[16'h1005]=8'h3C, A=8'h44, F=0, IDX_WAIT=5 → req at cycle 6 with addr 16'h1005; A=8'h80, F=8'h94.
- SUB, src=IY, IY=16'h0003, d=8'hFE, operand 8'h01, A=8'h10, F=0, ack delayed 3 cycles → addr 16'h0001 held with req=1 for 4 cycles; A=8'h0F, F=8'h12. Repeat with IX=16'hFFFF, d=8'h02 → addr 16'h0001.
- CP immediate n=8'h28, A=8'h20, XY_MODE=1 → done at cycle 2, no req; A=8'h20, F=8'hBB.
- SBC, src=HL, operand 8'h00, A=8'h00, F=8'h01, XY_MODE=0 → A=8'hFF, F=8'h93. Repeat with F=8'h29 → F=8'hBB (bits 5/3 preserved).
- reset_n=0 for one cycle during READ → next cycle req=0, busy=0, a_out=f_out=8'hFF, no done. A following start completes normally.
- start held high through an operation, and a stray ack in ADDR → exactly one done per accepted start; the stray ack is ignored.
